// File: rtl/msg_schedule.sv
// rtl/msg_schedule.sv - Streaming SHA-2 message schedule generator.
// Emits W_0..W_{ROUNDS-1} from a 16-word sliding window, one word per handshake.
module msg_schedule #(
  parameter  int WIDTH  = 32,
  localparam int ROUNDS = (WIDTH == 32) ? 64 : 80,
  localparam int IDXW   = $clog2(ROUNDS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [16*WIDTH-1:0]   block,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WIDTH-1:0]      w_out,
  output logic [IDXW-1:0]       w_idx,
  output logic                  w_last,
  output logic                  busy
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("msg_schedule: WIDTH must be 32 or 64");
  end

  localparam int S0_A = (WIDTH == 32) ? 7  : 1;
  localparam int S0_B = (WIDTH == 32) ? 18 : 8;
  localparam int S0_C = (WIDTH == 32) ? 3  : 7;
  localparam int S1_A = (WIDTH == 32) ? 17 : 19;
  localparam int S1_B = (WIDTH == 32) ? 19 : 61;
  localparam int S1_C = (WIDTH == 32) ? 10 : 6;
  localparam logic [IDXW-1:0] LAST_T = IDXW'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] win [16];
  logic [IDXW-1:0]  t;
  logic [WIDTH-1:0] w_new;
  logic             at_last;
  logic             accept;
  logic             load;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  function automatic logic [WIDTH-1:0] sig0(input logic [WIDTH-1:0] x);
    return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
  endfunction

  function automatic logic [WIDTH-1:0] sig1(input logic [WIDTH-1:0] x);
    return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
  endfunction

  assign at_last = (t == LAST_T);
  assign accept  = (state == RUN) && w_ready;
  assign load    = (state == IDLE) && load_valid;
  assign w_new   = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = RUN;
      RUN:     if (accept && at_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // The window is frozen on the final accept so w_out keeps showing the last word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      t <= '0;
    end else if (flush) begin
      t <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block[(16-i)*WIDTH-1 -: WIDTH];
      t <= '0;
    end else if (accept) begin
      if (at_last) begin
        t <= '0;
      end else begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
        t <= t + 1'b1;
      end
    end
  end

  assign load_ready = (state == IDLE);
  assign w_valid    = (state == RUN);
  assign busy       = (state == RUN);
  assign w_out      = win[0];
  assign w_idx      = t;
  assign w_last     = (state == RUN) && at_last;

endmodule
